// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes,
// opcode/func values and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXE_R    = 4'd2,
        S_EXE_I    = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JR       = 4'd11,
        S_LUI      = 4'd12,
        S_ERROR    = 4'd13
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_NONE = 3'b111;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_LUI = 2'b01;
    localparam logic [1:0] M2R_MDR = 2'b10;
    localparam logic [1:0] M2R_PC  = 2'b11;

    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_OUT = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;
    localparam logic [1:0] PCS_RS  = 2'b11;

endpackage

// File: rtl/mc_next_state.sv
// Next-state logic for the multi-cycle controller.
// Ports: state, op, func, mem_rdy in; next out. Macro: ILLEGAL_TRAP_EN.
module mc_next_state
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       mem_rdy,
    output state_t     next
);

    logic is_r;
    assign is_r = (op == OP_R);

    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:  next = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    (is_r && (func == FN_ADDU || func == FN_SUBU)):
                        next = S_EXE_R;
                    (is_r && func == FN_JR):          next = S_JR;
                    (op == OP_ORI):                   next = S_EXE_I;
                    (op == OP_LW || op == OP_SW):     next = S_MEM_ADDR;
                    (op == OP_BEQ):                   next = S_BRANCH;
                    (op == OP_JAL):                   next = S_JAL;
                    (op == OP_LUI):                   next = S_LUI;
                    default:                          next = S_ERROR;
                endcase
            end
            S_EXE_R:    next = S_WB_ALU;
            S_EXE_I:    next = S_WB_ALU;
            S_MEM_ADDR: next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   next = mem_rdy ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   next = mem_rdy ? S_FETCH : S_MEM_WR;
`ifdef ILLEGAL_TRAP_EN
            S_ERROR:    next = S_ERROR;
`else
            S_ERROR:    next = S_FETCH;
`endif
            default:    next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: Moore FSM, output decode, retire counter.
// Ports: clk, reset, op, func, zero, mem_ready in; datapath controls,
// retire, instr_cnt, state_dbg out. Macro: ILLEGAL_TRAP_EN (trap on ERROR).
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W     = 3,
    parameter int CNT_W         = 32,
    parameter int USE_MEM_READY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           func,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic                 ExtOp,
    output logic [ALUCTRL_W-1:0] ALUCtrl,
    output logic [1:0]           PCSource,
    output logic                 retire,
    output logic [CNT_W-1:0]     instr_cnt,
    output logic [3:0]           state_dbg
);

    state_t     state;
    state_t     next;
    logic       rdy;
    logic [2:0] alu;

    assign rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    mc_next_state u_ns (
        .state   (state),
        .op      (op),
        .func    (func),
        .mem_rdy (rdy),
        .next    (next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            instr_cnt <= '0;
        end else begin
            state <= next;
            if (retire)
                instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign state_dbg = state;
    assign ALUCtrl   = ALUCTRL_W'(alu);

    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = DST_RT;
        MemtoReg = M2R_ALU;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_RT;
        ExtOp    = 1'b0;
        alu      = 3'b000;
        PCSource = PCS_ALU;
        retire   = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_4;
                    alu     = ALU_ADD;
                    IRWrite = rdy;
                    PCWrite = rdy;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_BR;
                    alu     = ALU_ADD;
                end
                S_EXE_R: begin
                    ALUSrcA = 1'b1;
                    alu     = (func == FN_SUBU) ? ALU_SUB : ALU_ADD;
                end
                S_EXE_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    ExtOp   = 1'b1;
                    alu     = ALU_OR;
                end
                S_WB_ALU: begin
                    // op is held by the IR, so it still names the source
                    RegWrite = 1'b1;
                    RegDst   = (op == OP_R) ? DST_RD : DST_RT;
                    retire   = 1'b1;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                    alu     = ALU_ADD;
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = M2R_MDR;
                    retire   = 1'b1;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    retire   = rdy;
                end
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    alu      = ALU_SUB;
                    PCSource = PCS_OUT;
                    PCWrite  = zero;
                    retire   = 1'b1;
                end
                S_JAL: begin
                    RegWrite = 1'b1;
                    RegDst   = DST_RA;
                    MemtoReg = M2R_PC;
                    PCWrite  = 1'b1;
                    PCSource = PCS_JMP;
                    retire   = 1'b1;
                end
                S_JR: begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_RS;
                    retire   = 1'b1;
                end
                S_LUI: begin
                    RegWrite = 1'b1;
                    MemtoReg = M2R_LUI;
                    retire   = 1'b1;
                end
`ifndef ILLEGAL_TRAP_EN
                S_ERROR: retire = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected per-cycle control
// words are queued as stimulus is driven and compared at the falling edge.
module tb_multicycle_controller;

    localparam int A_OR  = 1;
    localparam int A_ADD = 2;
    localparam int A_SUB = 3;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mr, mw, ret, iord;
        logic [1:0] rdst, m2r, pcs;
        logic [2:0] alu;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'd0;
    logic [5:0]  func = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic        ALUSrcA, ExtOp, retire;
    logic [2:0]  ALUCtrl;
    logic [31:0] instr_cnt;
    logic [3:0]  state_dbg;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 0;
    rec_t        sb[$];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
        .ALUCtrl(ALUCtrl), .PCSource(PCSource), .retire(retire),
        .instr_cnt(instr_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic rec_t mk(int st, int pcw, int irw, int rw, int mr,
                                int mw, int ret, int iord, int rdst,
                                int m2r, int pcs, int alu);
        rec_t r;
        r.st = 4'(st);   r.pcw = 1'(pcw); r.irw = 1'(irw);
        r.rw = 1'(rw);   r.mr = 1'(mr);   r.mw = 1'(mw);
        r.ret = 1'(ret); r.iord = 1'(iord);
        r.rdst = 2'(rdst); r.m2r = 2'(m2r); r.pcs = 2'(pcs);
        r.alu = 3'(alu);
        return r;
    endfunction

    task automatic step(input rec_t e, input logic rdy);
        rec_t a;
        rec_t x;
        mem_ready = rdy;
        sb.push_back(e);
        @(negedge clk);
        a.st = state_dbg; a.pcw = PCWrite; a.irw = IRWrite;
        a.rw = RegWrite; a.mr = MemRead; a.mw = MemWrite;
        a.ret = retire; a.iord = IorD; a.rdst = RegDst;
        a.m2r = MemtoReg; a.pcs = PCSource; a.alu = ALUCtrl;
        x = sb.pop_front();
        check($sformatf("ctl_s%0d", x.st), 32'(a), 32'(x));
        check($sformatf("cnt_s%0d", x.st), instr_cnt, exp_cnt);
        if (x.ret) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
        op = o;
        func = f;
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++)
            step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, A_ADD), 1'b0);
        step(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, A_ADD), 1'b1);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD), 1'b1);
    endtask

    task automatic r_alu(input logic [5:0] f, input int alu);
        set_ir(6'b000000, f);
        fetch(0);
        step(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, alu), 1'b1);
        step(mk(7, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0), 1'b1);
    endtask

    task automatic beq(input logic z);
        set_ir(6'b000100, 6'd0);
        zero = z;
        fetch(0);
        step(mk(9, int'(z), 0, 0, 0, 0, 1, 0, 0, 0, 1, A_SUB), 1'b1);
        zero = 1'b0;
    endtask

    initial begin
        // Reset held two cycles; FETCH enables must be forced off.
        @(posedge clk);
        #1;
        exp_cnt = 0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        reset = 1'b0;

        r_alu(6'b100001, A_ADD);
        r_alu(6'b100011, A_SUB);

        // ori: writes rt
        set_ir(6'b001101, 6'd0);
        fetch(0);
        step(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_OR), 1'b1);
        step(mk(7, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1);

        // lw with 2 fetch waits and 1 memory wait: 8 cycles
        set_ir(6'b100011, 6'd0);
        fetch(2);
        step(mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD), 1'b1);
        step(mk(5, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0), 1'b0);
        step(mk(5, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0), 1'b1);
        step(mk(8, 0, 0, 1, 0, 0, 1, 0, 0, 2, 0, 0), 1'b1);

        // sw with one memory wait
        set_ir(6'b101011, 6'd0);
        fetch(0);
        step(mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD), 1'b1);
        step(mk(6, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0);
        step(mk(6, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), 1'b1);

        beq(1'b1);
        beq(1'b0);

        set_ir(6'b000011, 6'd0);
        fetch(0);
        step(mk(10, 1, 0, 1, 0, 0, 1, 0, 2, 3, 2, 0), 1'b1);

        set_ir(6'b000000, 6'b001000);
        fetch(0);
        step(mk(11, 1, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0), 1'b1);

        set_ir(6'b001111, 6'd0);
        fetch(0);
        step(mk(12, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0), 1'b1);

        // Reset during a stalled store: write suppressed, counter cleared
        set_ir(6'b101011, 6'd0);
        fetch(0);
        step(mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A_ADD), 1'b1);
        step(mk(6, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0);
        reset = 1'b1;
        step(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        exp_cnt = 0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        reset = 1'b0;

        r_alu(6'b100001, A_ADD);

        // Unknown R func and illegal opcode
        set_ir(6'b000000, 6'b111111);
        fetch(0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 12; i++)
            step(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        reset = 1'b1;
        step(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        exp_cnt = 0;
        reset = 1'b0;
        r_alu(6'b100011, A_SUB);
`else
        step(mk(13, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1);
        set_ir(6'b111111, 6'd0);
        fetch(0);
        step(mk(13, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1);
        r_alu(6'b100011, A_SUB);
`endif
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several cycles.
- Replaces the single-cycle op/func decoder.
- Drives the datapath muxes, register file, PC, IR and a shared instruction/data memory that uses a ready handshake.
- Adds a retired-instruction counter and illegal-opcode handling.

Parameters:
- ALUCTRL_W, 3, ALU control width; encodings 001 OR, 010 ADD, 011 SUB, 111 none.
- CNT_W, 32, width of the retired-instruction counter.
- USE_MEM_READY, 1, 1 = wait on mem_ready; 0 = memory treated as single-cycle and mem_ready ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26], stable from DECODE onward
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC load enable; already qualified by zero for beq
- IorD  out  1  memory address select: 0 PC, 1 ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load enable
- RegWrite  out  1  register file write enable
- RegDst  out  2  write register: 00 rt, 01 rd, 10 $31
- MemtoReg  out  2  write data: 00 ALUOut, 01 imm<<16, 10 MDR, 11 PC
- ALUSrcA  out  1  0 PC, 1 rs
- ALUSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2
- ExtOp  out  1  1 zero-extend, 0 sign-extend
- ALUCtrl  out  ALUCTRL_W  ALU operation
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
- retire  out  1  one-cycle pulse in each instruction's final cycle
- instr_cnt  out  CNT_W  count of retired instructions
- state_dbg  out  4  current state encoding

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset:
  - On a clock edge with reset high: state <= FETCH and instr_cnt <= 0.
  - While reset is high, all enables (PCWrite, IRWrite, RegWrite, MemRead, MemWrite, retire) are forced to 0 combinationally and every select output is 0.
  - A reset asserted mid-instruction aborts it with no further writes.
- Outputs are combinational from state, with two exceptions: PCWrite in BRANCH uses zero, and the FETCH, MEM_RD and MEM_WR enables use mem_ready. Unlisted outputs are 0.
- States (4-bit encoding): FETCH 0, DECODE 1, EXE_R 2, EXE_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JAL 10, JR 11, LUI 12, ERROR 13.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtrl=ADD, PCSource=00.
  - While mem_ready=0: stay in FETCH with IRWrite=PCWrite=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUCtrl=ADD (precomputes the branch target).
  - Dispatch:
    - R with func addu/subu -> EXE_R
    - R with func jr -> JR
    - ori -> EXE_I
    - lw/sw -> MEM_ADDR
    - beq -> BRANCH
    - jal -> JAL
    - lui -> LUI
    - anything else -> ERROR (see optional feature)
- EXE_R: ALUSrcA=1, ALUSrcB=00, ALUCtrl=ADD for addu or SUB for subu; -> WB_ALU with RegDst=01.
- EXE_I: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUCtrl=OR; -> WB_ALU with RegDst=00.
- WB_ALU: RegWrite=1, MemtoReg=00, RegDst held from the dispatch; retire; -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUCtrl=ADD; -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: IorD=1, MemRead=1; wait for mem_ready, then -> WB_MEM.
- WB_MEM: RegWrite=1, RegDst=00, MemtoReg=10; retire; -> FETCH.
- MEM_WR: IorD=1, MemWrite=1 held until mem_ready; retire on the mem_ready cycle; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtrl=SUB, PCSource=01, PCWrite=zero; retire; -> FETCH.
- JAL: RegWrite=1, RegDst=10, MemtoReg=11 (PC already holds PC+4), PCWrite=1, PCSource=10; retire; -> FETCH.
- JR: PCWrite=1, PCSource=11, RegWrite=0; retire; -> FETCH.
- LUI: RegWrite=1, RegDst=00, MemtoReg=01; retire; -> FETCH.
- Latency with zero-wait memory:
  - 3 cycles: beq, jal, jr, lui
  - 4 cycles: addu, subu, ori, sw
  - 5 cycles: lw
  - Each cycle mem_ready is low adds one cycle.
- instr_cnt: increments by 1 on each retire and wraps modulo 2^CNT_W.
- USE_MEM_READY=0: mem_ready is treated as constantly 1.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: ERROR is absorbing, with all enables 0 and state_dbg=13, until reset; no retire.
- Undefined: ERROR acts as a one-cycle NOP, with retire=1, then -> FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings
  - opcodes: R 000000, lw 100011, sw 101011, lui 001111, ori 001101, beq 000100, jal 000011
  - funcs: addu 100001, subu 100011, jr 001000
  - ALUCtrl, RegDst, MemtoReg, ALUSrcB and PCSource encodings
- One sub-module, mc_next_state: combinational next-state logic from state, op, func and mem_ready.
- The top module holds the state register, output decode and counter.

Test Plan:
- Reset held 2 cycles, then addu (op=0, func=100001) with mem_ready=1 -> states 0,1,2,7; RegWrite=1 with RegDst=01 only in cycle 4; instr_cnt=1.
- lw with mem_ready low for 2 cycles in FETCH and 1 cycle in MEM_RD -> 8 cycles total; IRWrite pulses once; WB_MEM has MemtoReg=10 and RegWrite=1.
- beq with zero=1, then beq with zero=0 -> PCWrite=1 with PCSource=01 in BRANCH for the first only; RegWrite stays 0 throughout.
- jal -> 3 cycles; JAL state has RegDst=10, MemtoReg=11, PCSource=10, PCWrite=1.
- op=111111 -> with ILLEGAL_TRAP_EN, state stays 13 for 10+ cycles and instr_cnt is unchanged; without it, returns to FETCH and instr_cnt increments.
- Reset asserted in MEM_WR -> no MemWrite on the following edge; state=0 and instr_cnt=0.
